// File: rtl/prng_pkg.sv
// ============================================================================
// Module  : prng_pkg
// Brief   : Shared types and constants for the PRNG scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package prng_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        STEP   = 3'd2,
        SETTLE = 3'd3,
        GRANT  = 3'd4
    } state_t;

    localparam logic [15:0] LFSR16_LOCKUP = 16'hFFFF;
    localparam logic [15:0] LFSR16_SAFE   = 16'hFFFE;

    // The all-ones state never leaves an XNOR LFSR, so it is never loaded.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == LFSR16_LOCKUP) ? LFSR16_SAFE : s;
    endfunction

    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prng_rr_arb.sv
// ============================================================================
// Module  : prng_rr_arb
// Brief   : Combinational round-robin pick: first set request at/after ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prng_rr_arb
    import prng_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] pick_o,
    output logic            found_o
);

    logic [PW-1:0] w_idx;

    always_comb begin
        pick_o  = '0;
        found_o = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = PW'((int'(ptr_i) + i) % NREQ);
            if (!found_o && req_i[w_idx]) begin
                pick_o[w_idx] = 1'b1;
                found_o       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prng_sched.sv
// ============================================================================
// Module  : prng_sched
// Brief   : Step-enable sequencer and round-robin arbiter for the LFSR datapath.
//           Optional macro PRNG_WHITEN_EN xors ctrl_sel into the captured byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prng_sched
    import prng_pkg::*;
#(
    parameter int NREQ            = 2,
    parameter int DIV_TICK        = 50_000_000,
    parameter int STEPS_PER_GRANT = 8
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            EN,
    input  logic            seed_load,
    input  logic [15:0]     seed_data,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [7:0]      rnd_data,
    input  logic [7:0]      mux_out,
    input  logic [7:0]      ctrl_sel,
    output logic            lfsr16_step,
    output logic            lfsr8_step,
    output logic            lfsr_load,
    output logic [15:0]     lfsr_seed,
    output logic            tick,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = (STEPS_PER_GRANT > 1) ? $clog2(STEPS_PER_GRANT) : 1;
    localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;

    state_t          state_q;
    logic [SW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [NREQ-1:0] sel_q;
    logic            seed_pend_q;
    logic [15:0]     seed_hold_q;
    logic [TW-1:0]   tick_cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic            rnd_valid_q;
    logic [7:0]      rnd_data_q;
    logic            lfsr16_step_q;
    logic            lfsr8_step_q;
    logic            lfsr_load_q;
    logic [15:0]     lfsr_seed_q;
    logic            tick_q;
    logic            busy_q;

    logic [NREQ-1:0] w_pick;
    logic            w_found;
    logic            w_seed_pend;
    logic [15:0]     w_seed_val;
    logic            w_seed_take;
    logic [7:0]      w_capture;

    prng_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (w_pick),
        .found_o (w_found)
    );

    // A pulse arriving in the same cycle is seen immediately by IDLE.
    assign w_seed_pend = seed_pend_q | seed_load;
    assign w_seed_val  = seed_load ? seed_data : seed_hold_q;
    assign w_seed_take = EN && (state_q == IDLE) && w_seed_pend;

`ifdef PRNG_WHITEN_EN
    assign w_capture = mux_out ^ ctrl_sel;
`else
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^ctrl_sel;
    assign w_capture     = mux_out;
`endif

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            seed_pend_q <= 1'b0;
            seed_hold_q <= '0;
        end else begin
            if (seed_load) seed_hold_q <= seed_data;
            if (w_seed_take)    seed_pend_q <= 1'b0;
            else if (seed_load) seed_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else if (!EN) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else if (tick_cnt_q == TW'(DIV_TICK - 1)) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            tick_q     <= 1'b0;
        end
    end

    // Strobes default low each cycle; a branch raises them for the cycle it enters.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= '0;
            sel_q         <= '0;
            gnt_q         <= '0;
            rnd_valid_q   <= 1'b0;
            rnd_data_q    <= '0;
            lfsr16_step_q <= 1'b0;
            lfsr8_step_q  <= 1'b0;
            lfsr_load_q   <= 1'b0;
            lfsr_seed_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            gnt_q         <= '0;
            rnd_valid_q   <= 1'b0;
            lfsr16_step_q <= 1'b0;
            lfsr8_step_q  <= 1'b0;
            lfsr_load_q   <= 1'b0;
            busy_q        <= 1'b0;
            if (!EN) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (w_seed_take) begin
                            state_q     <= SEED;
                            lfsr_load_q <= 1'b1;
                            lfsr_seed_q <= seed_fix(w_seed_val);
                            busy_q      <= 1'b1;
                        end else if (w_found) begin
                            state_q       <= STEP;
                            sel_q         <= w_pick;
                            cnt_q         <= '0;
                            lfsr16_step_q <= 1'b1;
                            lfsr8_step_q  <= (STEPS_PER_GRANT == 1);
                            busy_q        <= 1'b1;
                        end
                    end
                    SEED: begin
                        state_q <= IDLE;
                    end
                    STEP: begin
                        busy_q <= 1'b1;
                        if (cnt_q == SW'(STEPS_PER_GRANT - 1)) begin
                            state_q <= SETTLE;
                        end else begin
                            cnt_q         <= cnt_q + 1'b1;
                            lfsr16_step_q <= 1'b1;
                            lfsr8_step_q  <= (cnt_q == SW'(STEPS_PER_GRANT - 2));
                        end
                    end
                    SETTLE: begin
                        state_q     <= GRANT;
                        rnd_data_q  <= w_capture;
                        gnt_q       <= sel_q;
                        rnd_valid_q <= 1'b1;
                        ptr_q       <= PW'((int'(oh_to_idx(8'(sel_q))) + 1) % NREQ);
                        busy_q      <= 1'b1;
                    end
                    GRANT: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign gnt         = gnt_q;
    assign rnd_valid   = rnd_valid_q;
    assign rnd_data    = rnd_data_q;
    assign lfsr16_step = lfsr16_step_q;
    assign lfsr8_step  = lfsr8_step_q;
    assign lfsr_load   = lfsr_load_q;
    assign lfsr_seed   = lfsr_seed_q;
    assign tick        = tick_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_prng_sched.sv
// ============================================================================
// Module  : tb_prng_sched
// Brief   : Directed bench with a grant scoreboard for prng_sched.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prng_sched;

    localparam int NREQ  = 2;
    localparam int DIV   = 5;
    localparam int STEPS = 8;

    logic            CLK = 1'b0;
    logic            rst = 1'b0;
    logic            EN = 1'b0;
    logic            seed_load = 1'b0;
    logic [15:0]     seed_data = '0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [7:0]      rnd_data;
    logic [7:0]      mux_out = '0;
    logic [7:0]      ctrl_sel = '0;
    logic            lfsr16_step;
    logic            lfsr8_step;
    logic            lfsr_load;
    logic [15:0]     lfsr_seed;
    logic            tick;
    logic            busy;

    prng_sched #(
        .NREQ            (NREQ),
        .DIV_TICK        (DIV),
        .STEPS_PER_GRANT (STEPS)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .EN          (EN),
        .seed_load   (seed_load),
        .seed_data   (seed_data),
        .req         (req),
        .gnt         (gnt),
        .rnd_valid   (rnd_valid),
        .rnd_data    (rnd_data),
        .mux_out     (mux_out),
        .ctrl_sel    (ctrl_sel),
        .lfsr16_step (lfsr16_step),
        .lfsr8_step  (lfsr8_step),
        .lfsr_load   (lfsr_load),
        .lfsr_seed   (lfsr_seed),
        .tick        (tick),
        .busy        (busy)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [7:0]      d;
        int              c;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] m, input logic [7:0] c);
`ifdef PRNG_WHITEN_EN
        return m ^ c;
`else
        return m;
`endif
    endfunction

    task automatic push(input logic [NREQ-1:0] g, input logic [7:0] d, input int c);
        exp_t e;
        e.g = g;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Monitor: step-run accounting and scoreboard pop on every grant.
    initial begin
        int   n16;
        int   n8;
        logic prev16;
        exp_t e;
        n16    = 0;
        n8     = 0;
        prev16 = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (lfsr16_step) begin
                    if (!prev16) begin
                        n16 = 0;
                        n8  = 0;
                    end
                    n16++;
                end
                if (lfsr8_step) begin
                    n8++;
                    chk("l8_on_last_step", n16, STEPS);
                end
                prev16 = lfsr16_step;
                if (lfsr_load) chk("load_vs_step", {lfsr16_step, lfsr8_step}, 0);
                if (gnt != 0 || rnd_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_gnt", {gnt, rnd_valid}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("gnt", gnt, e.g);
                        chk("rnd_valid", rnd_valid, 1);
                        chk("rnd_data", rnd_data, e.d);
                        if (e.c >= 0) chk("gnt_cycle", cyc, e.c);
                        chk("l16_count", n16, STEPS);
                        chk("l8_count", n8, 1);
                    end
                end
            end
        end
    end

    initial begin
        int s;
        // Reset
        repeat (3) @(negedge CLK);
        chk("rst_outputs", {gnt, rnd_valid, rnd_data, lfsr16_step, lfsr8_step,
                            lfsr_load, tick}, 0);
        chk("rst_seed", lfsr_seed, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge CLK);
        mon_en = 1'b1;

        // Round-robin with both requesters held
        @(negedge CLK);
        s        = cyc;
        EN       = 1'b1;
        req      = 2'b11;
        mux_out  = 8'h3C;
        ctrl_sel = 8'h81;
        push(2'b01, exp_byte(8'h3C, 8'h81), s + 10);
        push(2'b10, exp_byte(8'h3C, 8'h81), s + 21);
        push(2'b01, exp_byte(8'h3C, 8'h81), s + 32);
        push(2'b10, exp_byte(8'h3C, 8'h81), s + 43);
        wait_cyc(s + 1);
        chk("busy_in_step", busy, 1);
        wait_cyc(s + 43);
        req = '0;
        wait_drain(20);

        // Lock-up seed substitution while idle
        @(negedge CLK);
        s         = cyc;
        seed_load = 1'b1;
        seed_data = 16'hFFFF;
        @(negedge CLK);
        seed_load = 1'b0;
        chk("seed_ffff_load", lfsr_load, 1);
        chk("seed_ffff_value", lfsr_seed, 16'hFFFE);
        chk("rnd_data_hold", rnd_data, exp_byte(8'h3C, 8'h81));
        @(negedge CLK);
        chk("load_one_cycle", lfsr_load, 0);
        chk("idle_after_seed", busy, 0);

        // Seed and request in the same cycle: seed served first
        @(negedge CLK);
        s         = cyc;
        mux_out   = 8'h5A;
        ctrl_sel  = 8'h00;
        seed_load = 1'b1;
        seed_data = 16'h1234;
        req       = 2'b01;
        push(2'b01, exp_byte(8'h5A, 8'h00), s + 12);
        @(negedge CLK);
        seed_load = 1'b0;
        chk("seed_first_load", lfsr_load, 1);
        chk("seed_first_value", lfsr_seed, 16'h1234);
        wait_drain(20);
        req = '0;

        // Seed pulses mid-sequence: grant unaffected, latest seed served after
        @(negedge CLK);
        s        = cyc;
        req      = 2'b10;
        mux_out  = 8'hC3;
        ctrl_sel = 8'hFF;
        push(2'b10, exp_byte(8'hC3, 8'hFF), s + 10);
        wait_cyc(s + 3);
        seed_load = 1'b1;
        seed_data = 16'hAAAA;
        @(negedge CLK);
        seed_data = 16'h5555;
        @(negedge CLK);
        seed_load = 1'b0;
        wait_drain(20);
        req = '0;
        wait_cyc(s + 12);
        chk("pend_seed_load", lfsr_load, 1);
        chk("pend_seed_value", lfsr_seed, 16'h5555);

        // EN dropped in the 4th step cycle
        @(negedge CLK);
        @(negedge CLK);
        s        = cyc;
        req      = 2'b11;
        mux_out  = 8'hA5;
        ctrl_sel = 8'h0F;
        wait_cyc(s + 4);
        chk("abort_step4", lfsr16_step, 1);
        EN = 1'b0;
        @(negedge CLK);
        chk("abort_strobes", {lfsr16_step, lfsr8_step, lfsr_load}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_gnt", {gnt, rnd_valid}, 0);
        EN = 1'b1;
        push(2'b01, exp_byte(8'hA5, 8'h0F), cyc + 10);
        wait_drain(20);
        req = '0;
        chk("whiten_capture", rnd_data, exp_byte(8'hA5, 8'h0F));

        // Tick divider
        @(negedge CLK);
        EN = 1'b0;
        @(negedge CLK);
        EN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            chk($sformatf("tick_%0d", i), tick, (i % 5 == 0));
        end
        repeat (2) @(negedge CLK);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("tick_en_low", tick, 0);
        end
        EN = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            chk($sformatf("tick_restart_%0d", i), tick, (i == 5));
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
